// File: rtl/mult_operand_sequencer.sv
// Operand FIFO and restart/latency sequencer in front of the shift-and-add multiplier.
// Presents each product on a valid/ready result port, in the order the operand pairs arrived.
module mult_operand_sequencer #(
   parameter int M     = 4,
   parameter int N     = 4,
   parameter int LAT   = 4,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [M-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           mul_rst,
   output logic [M-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   input  logic [M+N-1:0] mul_c,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [M+N-1:0] res_data,
   output logic           busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

   state_t        state, state_nxt;
   logic [PW:0]   count, count_nxt;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   logic [M-1:0]  mem_a [DEPTH];
   logic [N-1:0]  mem_b [DEPTH];
   logic          push, pop, done;

   assign in_ready = (count != (PW+1)'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (state == LOAD);
   assign done     = (state == RUN) && (cnt == CW'(LAT - 1));

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + 1'b1;
      else if (!push && pop)
         count_nxt = count - 1'b1;
   end

   // Next-state decisions use the registered count, so a pair pushed this cycle waits one cycle
   always_comb begin
      state_nxt = state;
      mul_rst   = 1'b1;
      case (state)
         IDLE: if (count != '0) state_nxt = LOAD;
         LOAD: state_nxt = RUN;
         RUN: begin
            mul_rst = 1'b0;
            if (done) state_nxt = HOLD;
         end
         HOLD: if (res_ready) state_nxt = (count != '0) ? LOAD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         busy  <= (state_nxt != IDLE) || (count_nxt != '0);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            mul_a  <= mem_a[rd_ptr];
            mul_b  <= mem_b[rd_ptr];
            cnt    <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
         end
         if (done) begin
            res_data  <= mul_c;
            res_valid <= 1'b1;
         end else if (state == HOLD && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

   // Storage needs no reset: the count alone decides which entries are live
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= in_a;
         mem_b[wr_ptr] <= in_b;
      end
   end

endmodule
